// File: rtl/multi_edge_detector.sv
// ---------------------------------------------------------------------------
// multi_edge_detector
//
// Multi-channel edge detector for the AXI interconnect utils library.
// Each channel passes its input through an optional synchroniser and a
// glitch filter. Rising and/or falling transitions of the filtered level
// that the channel's mode allows produce:
//    - a registered one-cycle pulse,
//    - a sticky pending flag that can be cleared, and
//    - a saturating event counter that can be cleared.
//
// Parameters:
//    NUM_CH        number of independent channels (>= 1)
//    SYNC_STAGES   synchroniser flops per channel
//                  (0 = sig_in is already synchronous to ACLK)
//    FILTER_CYCLES extra consecutive cycles a new level must persist
//                  before it is accepted (0 = no filtering)
//    CNT_WIDTH     width of each per-channel event counter
//    INIT_LEVEL    reset value of the synchroniser and filtered level,
//                  replicated to every bit
//
// Ports:
//    ACLK          clock
//    ARESETN       asynchronous active-low reset
//    sig_in        monitored signals, may be asynchronous
//    mode_sel      per-channel mode, ch i at [2i+1:2i]
//                  00 off, 01 rising, 10 falling, 11 both
//    clear_pending per-channel clear of edge_pending
//    count_clear   per-channel clear of edge_count
//    level_out     filtered level per channel
//    edge_pulse    registered one-cycle pulse per qualifying edge
//    edge_pending  sticky edge flag per channel
//    any_pending   OR of edge_pending
//    edge_count    saturating counter per channel,
//                  ch i at [CNT_WIDTH*(i+1)-1:CNT_WIDTH*i]
// ---------------------------------------------------------------------------
module multi_edge_detector #(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 0,
   parameter int CNT_WIDTH     = 8,
   parameter bit INIT_LEVEL    = 1'b0
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [NUM_CH-1:0]             sig_in,
   input  logic [2*NUM_CH-1:0]           mode_sel,
   input  logic [NUM_CH-1:0]             clear_pending,
   input  logic [NUM_CH-1:0]             count_clear,
   output logic [NUM_CH-1:0]             level_out,
   output logic [NUM_CH-1:0]             edge_pulse,
   output logic [NUM_CH-1:0]             edge_pending,
   output logic                          any_pending,
   output logic [NUM_CH*CNT_WIDTH-1:0]   edge_count
);

   // The filter counter must at least hold FILTER_CYCLES; keep it one bit
   // wide when filtering is disabled so the logic stays uniform.
   localparam int FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam logic [NUM_CH-1:0] INIT_VEC = {NUM_CH{INIT_LEVEL}};

   logic [NUM_CH-1:0] sync_out;

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
               for (int k = 0; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= INIT_VEC;
               end
            end else begin
               sync_q[0] <= sig_in;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign sync_out = sync_q[SYNC_STAGES-1];
      end else begin : g_nosync
         assign sync_out = sig_in;
      end
   endgenerate

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         logic [FW-1:0]        fcnt;
         logic                 level_q;
         logic                 pulse_q;
         logic                 pend_q;
         logic [CNT_WIDTH-1:0] cnt_q;
         logic [1:0]           mode;
         logic                 accept;
         logic                 qualify;

         assign mode = mode_sel[2*i+1 -: 2];

         // A differing level is accepted once it has already been seen
         // FILTER_CYCLES times in a row; the accepted value is sync_out[i].
         assign accept = (sync_out[i] != level_q) &&
                         (fcnt == FW'(FILTER_CYCLES));

         // New level 1 means a rising edge (mode bit 0), new level 0 a
         // falling edge (mode bit 1).
         assign qualify = accept && (sync_out[i] ? mode[0] : mode[1]);

         always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
               fcnt    <= '0;
               level_q <= INIT_LEVEL;
            end else if (sync_out[i] == level_q) begin
               fcnt <= '0;
            end else if (accept) begin
               level_q <= sync_out[i];
               fcnt    <= '0;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end

         // Set beats clear for the pending flag; a clear coinciding with a
         // qualified edge restarts the counter at one.
         always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
               pulse_q <= 1'b0;
               pend_q  <= 1'b0;
               cnt_q   <= '0;
            end else begin
               pulse_q <= qualify;
               pend_q  <= qualify | (pend_q & ~clear_pending[i]);
               if (qualify) begin
                  if (count_clear[i]) begin
                     cnt_q <= CNT_WIDTH'(1);
                  end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (count_clear[i]) begin
                  cnt_q <= '0;
               end
            end
         end

         assign level_out[i]                           = level_q;
         assign edge_pulse[i]                          = pulse_q;
         assign edge_pending[i]                        = pend_q;
         assign edge_count[CNT_WIDTH*i +: CNT_WIDTH]   = cnt_q;
      end
   endgenerate

   assign any_pending = |edge_pending;

endmodule
